// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised show-ahead FIFO.
package fifo_pkg;

    localparam int unsigned ERR_FLAGS_W = 2;
    localparam int unsigned ERR_OVF     = 0;
    localparam int unsigned ERR_UNF     = 1;

    typedef logic [ERR_FLAGS_W-1:0] err_flags_t;

    // Pointer width carries one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for param_fifo: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Show-ahead FIFO with occupancy count, almost flags and synchronous flush.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module param_fifo
    import fifo_pkg::*;
#(
    parameter string       name       = "param_fifo",
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                                 sys_clock_i,
    input  logic                                 sys_reset_i,
    input  logic                                 flush_i,
    input  logic                                 write_i,
    input  logic [DATA_WIDTH-1:0]                data_i,
    input  logic                                 read_i,
    output logic [DATA_WIDTH-1:0]                data_o,
    output logic                                 empty_o,
    output logic                                 full_o,
    output logic                                 almost_empty_o,
    output logic                                 almost_full_o,
    output logic [ptr_width(FIFO_DEPTH)-1:0]     count_o,
    output logic                                 overflow_o,
    output logic                                 underflow_o,
    input  logic                                 err_clr_i
);

    localparam int unsigned PtrW  = ptr_width(FIFO_DEPTH);
    localparam int unsigned AddrW = PtrW - 1;

    localparam logic [PtrW-1:0] AfLevel = PtrW'(AF_LEVEL);
    localparam logic [PtrW-1:0] AeLevel = PtrW'(AE_LEVEL);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            wr_ok, rd_ok;

    assign empty_o = (rd_ptr_q == wr_ptr_q);
    assign full_o  = (rd_ptr_q[AddrW-1:0] == wr_ptr_q[AddrW-1:0]) &&
                     (rd_ptr_q[AddrW] != wr_ptr_q[AddrW]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign almost_empty_o = (count_o <= AeLevel);
    assign almost_full_o  = (count_o >= AfLevel);

    // A write into a full FIFO is fine when the same cycle pops the head slot.
    assign wr_ok = write_i & (~full_o | read_i);
    assign rd_ok = read_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (AddrW)
    ) u_ram (
        .clk   (sys_clock_i),
        .we    (wr_ok & ~flush_i),
        .waddr (wr_ptr_q[AddrW-1:0]),
        .wdata (data_i),
        .raddr (rd_ptr_q[AddrW-1:0]),
        .rdata (data_o)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic       wr_rej, rd_rej;
    err_flags_t err_q, err_d;

    assign wr_rej = write_i & ~wr_ok;
    assign rd_rej = read_i & empty_o;

    always_comb begin
        err_d = err_q;
        if (wr_rej) err_d[ERR_OVF] = 1'b1;
        if (rd_rej) err_d[ERR_UNF] = 1'b1;
        if (err_clr_i) err_d = '0;
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign overflow_o  = err_q[ERR_OVF];
    assign underflow_o = err_q[ERR_UNF];

`ifndef SYNTHESIS
    always_ff @(posedge sys_clock_i) begin
        if (sys_reset_i && (wr_rej || rd_rej)) begin
            $display("%s: rejected %s rd_ptr=%0d wr_ptr=%0d", name,
                     wr_rej ? "write" : "read", rd_ptr_q, wr_ptr_q);
        end
    end
`endif
`else
    localparam string unused_name = name;
    logic unused_err_clr;

    assign unused_err_clr = err_clr_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif

endmodule
